// File: rtl/output_writer_pkg.sv
// Shared definitions for the output writer: FSM state encoding and the
// width of one data lane.
package output_writer_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, single clock, asynchronous active-high reset.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// Ports:
//   clk, rst        clock and asynchronous reset
//   clr             synchronous flush (pointers and count to 0)
//   push, din       write request and data
//   pop             read request; dout is the current head
//   full, empty     occupancy flags
//   count           number of stored entries (0..DEPTH)
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PW+1)'(DEPTH));
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign pop_ok  = pop && !empty;
    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop_ok};
        end
    end

endmodule

// File: rtl/output_writer.sv
// Output writer: buffers post-processed beats in a small FIFO and writes
// them to consecutive memory addresses starting at base_addr.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   start, base_addr, num_beats job launch (sampled in IDLE)
//   post_out, post_out_valid   incoming beats (no backpressure upstream)
//   wr_en, wr_addr, wr_data    memory write request, held until wr_ready
//   wr_ready                   memory accepts the request
//   busy, done, overflow       job status; overflow is sticky per job
module output_writer
    import output_writer_pkg::*;
#(
    parameter int POX   = 3,
    parameter int DEPTH = 4,
    parameter int AW    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [AW-1:0]         base_addr,
    input  logic [AW-1:0]         num_beats,
    input  logic [POX*DATA_W-1:0] post_out,
    input  logic                  post_out_valid,
    output logic                  wr_en,
    output logic [AW-1:0]         wr_addr,
    output logic [POX*DATA_W-1:0] wr_data,
    input  logic                  wr_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int LW = POX * DATA_W;
    localparam int CW = $clog2(DEPTH) + 1;

    state_t          state_q;
    logic [AW-1:0]   addr_q;
    logic [AW-1:0]   num_q;
    logic [AW-1:0]   acc_q;
    logic [AW-1:0]   wr_cnt_q;
    logic            overflow_q;

    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [LW-1:0]   fifo_head;

    logic            in_run;
    logic            start_acc;
    logic            beat_wanted;
    logic            push;
    logic            pop;
    logic            drop;

    assign in_run      = (state_q == RUN);
    assign start_acc   = (state_q == IDLE) && start;
    assign pop         = wr_en && wr_ready;
    // Only beats that still count towards the job are candidates; extras are ignored.
    assign beat_wanted = in_run && post_out_valid && (acc_q < num_q);
    assign push        = beat_wanted && (!fifo_full || pop);
    assign drop        = beat_wanted && (fifo_count == CW'(DEPTH)) && !pop;

    assign wr_en    = in_run && !fifo_empty;
    assign wr_addr  = addr_q;
    assign wr_data  = fifo_head;
    assign busy     = in_run;
    assign done     = (state_q == DONE);
    assign overflow = overflow_q;

    sync_fifo #(
        .WIDTH (LW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_acc),
        .push  (push),
        .din   (post_out),
        .pop   (pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            num_q      <= '0;
            acc_q      <= '0;
            wr_cnt_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q     <= base_addr;
                        num_q      <= num_beats;
                        acc_q      <= '0;
                        wr_cnt_q   <= '0;
                        overflow_q <= 1'b0;
                        state_q    <= (num_beats != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (push) begin
                        acc_q <= acc_q + 1'b1;
                    end
                    if (pop) begin
                        addr_q   <= addr_q + 1'b1;   // wraps modulo 2^AW
                        wr_cnt_q <= wr_cnt_q + 1'b1;
                    end
                    if (drop) begin
                        overflow_q <= 1'b1;
                    end
                    // Dropped beats never reach memory, so a job that lost
                    // beats stays here until more beats arrive or reset.
                    if (wr_cnt_q == num_q) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_writer.sv
// Scoreboard bench for output_writer: the driver runs a job-level model and
// queues expected writes; a monitor checks every memory transfer in order.
module tb_output_writer;

    localparam int POX   = 3;
    localparam int DEPTH = 4;
    localparam int AW    = 16;
    localparam int LW    = POX * 16;

    localparam int MI = 0;  // idle
    localparam int MR = 1;  // running
    localparam int MD = 2;  // done cycle

    typedef struct {
        logic [AW-1:0] a;
        logic [LW-1:0] d;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] num_beats = '0;
    logic [LW-1:0] post_out = '0;
    logic          post_out_valid = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [LW-1:0] wr_data;
    logic          wr_ready = 1'b0;
    logic          busy;
    logic          done;
    logic          overflow;

    int total = 0;
    int bad   = 0;

    exp_t expq[$];
    int            m_ph = MI;
    logic [AW-1:0] m_base, m_n, m_acc, m_wr;
    int            m_occ = 0;
    bit            m_ovf = 1'b0;
    int            done_cnt = 0;

    bit            hold_v = 1'b0;
    logic [AW-1:0] h_addr;
    logic [LW-1:0] h_data;

    always #5 clk = ~clk;

    output_writer #(.POX(POX), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .base_addr      (base_addr),
        .num_beats      (num_beats),
        .post_out       (post_out),
        .post_out_valid (post_out_valid),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exv);
        total++;
        if (act !== exv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exv);
        end
    endtask

    // Monitor: checks every transfer against the scoreboard and holding of
    // the request while the memory stalls.
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (hold_v) begin
                chk("hold_en", wr_en, 1);
                chk("hold_addr", wr_addr, h_addr);
                chk("hold_data", wr_data, h_data);
            end
            if (wr_en === 1'b1 && wr_ready === 1'b1) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got write to %0h, expected none", wr_addr);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("wr_addr", wr_addr, e.a);
                    chk("wr_data", wr_data, e.d);
                end
            end
            hold_v = (wr_en === 1'b1) && (wr_ready === 1'b0);
            h_addr = wr_addr;
            h_data = wr_data;
        end
    end

    // One clock cycle of stimulus, output check and model update.
    task automatic step(input bit st, input logic [AW-1:0] b, input logic [AW-1:0] n,
                        input bit v, input bit rdy);
        logic [LW-1:0] d;
        logic [AW-1:0] ea;
        bit pop, want, acc;
        d[31:0]  = $urandom();
        d[47:32] = 16'($urandom());
        @(posedge clk);
        #1;
        start          = st;
        if (st) begin
            base_addr = b;
            num_beats = n;
        end
        post_out       = d;
        post_out_valid = v;
        wr_ready       = rdy;
        @(negedge clk);
        #1;
        chk("wr_en", wr_en, (m_ph == MR) && (m_occ > 0));
        chk("busy", busy, m_ph == MR);
        chk("done", done, m_ph == MD);
        chk("overflow", overflow, m_ovf);
        chk("fifo_count", dut.u_fifo.count, m_occ);
        case (m_ph)
            MI: begin
                if (st) begin
                    m_base = b; m_n = n; m_acc = '0; m_wr = '0;
                    m_occ = 0; m_ovf = 1'b0;
                    m_ph = (n != 0) ? MR : MD;
                end
            end
            MR: begin
                if (m_wr == m_n) begin
                    m_ph = MD;
                end else begin
                    pop  = (m_occ > 0) && rdy;
                    want = v && (m_acc < m_n);
                    acc  = want && ((m_occ < DEPTH) || pop);
                    if (want && !acc) m_ovf = 1'b1;
                    if (acc) begin
                        ea = m_base + m_acc;
                        expq.push_back('{a: ea, d: d});
                        m_acc = m_acc + 1'b1;
                    end
                    if (pop) m_wr = m_wr + 1'b1;
                    m_occ = m_occ + (acc ? 1 : 0) - (pop ? 1 : 0);
                end
            end
            default: m_ph = MI;
        endcase
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        start = 1'b0;
        post_out_valid = 1'b0;
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        m_ph = MI;
        m_occ = 0;
        m_ovf = 1'b0;
        expq.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int d0;
        logic [AW-1:0] rb;
        logic [AW-1:0] rn;

        do_reset();
        step(0, 0, 0, 1, 1);            // beat in IDLE is ignored
        step(0, 0, 0, 0, 1);

        // Basic job: three beats, memory always ready.
        d0 = done_cnt;
        step(1, 16'h0100, 16'd3, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
        chk("basic_done_pulses", done_cnt - d0, 1);

        // Backpressure: six beats into a four-entry FIFO, then drain.
        d0 = done_cnt;
        step(1, 16'h0300, 16'd6, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1);
        chk("bp_no_done", done_cnt - d0, 0);
        do_reset();

        // Full FIFO with a simultaneous pop and push.
        step(1, 16'h0400, 16'd8, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);

        // Zero-length job.
        d0 = done_cnt;
        step(1, 16'h0500, 16'd0, 0, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        chk("zero_done_pulses", done_cnt - d0, 1);

        // Address wrap.
        step(1, 16'hFFFF, 16'd2, 0, 1);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);

        // Reset in the middle of a job, then a fresh short job.
        d0 = done_cnt;
        step(1, 16'h0600, 16'd5, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1);
        do_reset();
        chk("midrst_no_done", done_cnt - d0, 0);
        d0 = done_cnt;
        step(1, 16'h0200, 16'd1, 0, 1);
        step(0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
        chk("after_rst_done", done_cnt - d0, 1);

        // Randomized jobs with random valid and ready patterns.
        for (int j = 0; j < 15; j++) begin
            rn = 16'($urandom_range(1, 10));
            rb = 16'($urandom());
            if (j == 3) rb = 16'hFFFC;
            step(1, rb, rn, 0, 1);
            for (int c = 0; c < 300 && m_ph != MI; c++) begin
                step(0, 0, 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
            end
            if (m_ph != MI) do_reset();
        end

        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        chk("scoreboard_drained", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/output_writer.md
OUTPUT_WRITER -- requirements
Module: output_writer

Interface
REQ-001 The block SHALL have parameter POX, default 3, meaning the number of 16-bit lanes per beat.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the FIFO entries; it SHALL be a power of two, at least 2.
REQ-003 The block SHALL have parameter AW, default 16, meaning the address and beat-count width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: a one-cycle job launch, sampled only in IDLE.
REQ-007 The block SHALL have port base_addr, input, AW bits: first write address, sampled when start is accepted.
REQ-008 The block SHALL have port num_beats, input, AW bits: beats to store, sampled when start is accepted.
REQ-009 The block SHALL have port post_out, input, POX*16 bits: the post-processed beat from the upstream post-process stage.
REQ-010 The block SHALL have port post_out_valid, input, 1 bit: post_out is valid this cycle; there is no backpressure to upstream.
REQ-011 The block SHALL have port wr_en, output, 1 bit: a memory write request.
REQ-012 The block SHALL have port wr_addr, output, AW bits: the write address.
REQ-013 The block SHALL have port wr_data, output, POX*16 bits: the write data.
REQ-014 The block SHALL have port wr_ready, input, 1 bit: the memory accepts the request; a transfer occurs when wr_en and wr_ready are both 1.
REQ-015 The block SHALL have port busy, output, 1 bit: high in RUN.
REQ-016 The block SHALL have port done, output, 1 bit: a one-cycle pulse at job end.
REQ-017 The block SHALL have port overflow, output, 1 bit: sticky; a beat arrived while the FIFO was full with no pop that cycle.

Function
REQ-018 The FSM SHALL have states IDLE, RUN and DONE, with the following transitions:
- IDLE→RUN on start with num_beats≠0.
- IDLE→DONE on start with num_beats=0.
- RUN→DONE when the written count equals num_beats.
- DONE→IDLE unconditionally after one cycle.
REQ-019 On start acceptance the block SHALL load the address counter with base_addr, clear the accepted and written counters, clear overflow and empty the FIFO.
REQ-020 In RUN, a beat SHALL be accepted when post_out_valid=1, the accepted count is below num_beats, and either the FIFO is not full or a pop occurs in the same cycle.
REQ-021 Each accepted beat SHALL increment the accepted count by 1.
REQ-022 Beats in IDLE or DONE, and beats after num_beats have been accepted, SHALL be silently ignored and SHALL NOT set overflow.
REQ-023 In RUN, a beat with post_out_valid=1, the FIFO full, no pop that cycle and the accepted count below num_beats SHALL be dropped and SHALL set overflow; overflow stays 1 until the next accepted start.
REQ-024 wr_en SHALL be 1 exactly when the state is RUN and the FIFO is not empty.
REQ-025 wr_data SHALL equal the FIFO head and wr_addr SHALL equal the address counter, both driven from registers only.
REQ-026 wr_en, wr_addr and wr_data SHALL be held stable while wr_ready=0.
REQ-027 On each transfer the block SHALL pop the FIFO, increment the address by 1 (modulo 2^AW, wrapping silently) and increment the written count.
REQ-028 Latency: a beat accepted in cycle N SHALL appear on wr_en/wr_data no earlier than cycle N+1, and in cycle N+1 when the FIFO was empty before the push.
REQ-029 FIFO read and write pointers SHALL wrap modulo DEPTH; beat order SHALL be preserved.
REQ-030 done SHALL be 1 only in DONE; busy SHALL be 1 only in RUN.

Reset
REQ-031 While rst=1, and independent of clk, the block SHALL force:
- state to IDLE;
- FIFO pointers, FIFO count, all counters and the address counter to 0;
- wr_en, done, busy and overflow to 0;
- wr_addr and wr_data to 0.
REQ-032 A reset asserted mid-job SHALL abandon the job with no done pulse; a new start is required afterwards.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding (IDLE=0, RUN=1, DONE=2, 2 bits) and the lane width constant DATA_W=16.
REQ-034 The FIFO SHALL be a separate sub-module, sync_fifo, parameterised by width and DEPTH, with push/pop/full/empty/count ports and the same clk and rst.

Verification
REQ-035 Basic job: base_addr=0x0100, num_beats=3, three valid beats with wr_ready=1 → writes to 0x0100, 0x0101, 0x0102 with the matching data, each one cycle after its beat; done pulses once; overflow=0.
REQ-036 Backpressure: DEPTH=4, wr_ready=0, six consecutive valid beats with num_beats=6 → first four stored, overflow=1; after wr_ready=1, four writes occur in order and done never asserts.
REQ-037 Full with simultaneous pop: FIFO full, wr_ready=1 and post_out_valid=1 in the same cycle → the beat is accepted, FIFO count is unchanged and overflow stays 0.
REQ-038 Edge jobs:
- num_beats=0 → done pulses in the cycle after start with no wr_en.
- base_addr=0xFFFF with num_beats=2 → writes to 0xFFFF then 0x0000.
REQ-039 Reset mid-job: rst asserted after 2 of 5 writes → all outputs 0 immediately; a new start with base_addr=0x0200 and num_beats=1 completes normally.
